// File: rtl/mms_pwm_gen.sv
// Three-leg centre-aligned PWM generator for the min-max modulation path:
// sign-magnitude reference scaling, valley-buffered compare, dead time and trip latch.
module mms_pwm_gen #(
  parameter int N           = 24,
  parameter int Q           = 12,
  parameter int PERIOD_HALF = 2048,
  parameter int CNT_W       = 12,
  parameter int DEAD        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     ref_a,
  input  logic [N-1:0]     ref_b,
  input  logic [N-1:0]     ref_c,
  input  logic             ref_valid,
  input  logic             trip,
  input  logic             trip_clr,
  output logic             gate_ah,
  output logic             gate_al,
  output logic             gate_bh,
  output logic             gate_bl,
  output logic             gate_ch,
  output logic             gate_cl,
  output logic             pwm_sync,
  output logic             tripped,
  output logic [CNT_W-1:0] carrier
);

  localparam int DW = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
  localparam int PW = Q + 2 + CNT_W;
  localparam logic [CNT_W-1:0] PH_C   = CNT_W'(PERIOD_HALF);
  localparam logic [CNT_W-1:0] MID_C  = CNT_W'(PERIOD_HALF / 2);
  localparam logic [DW-1:0]    DEAD_C = DW'(DEAD);
  localparam logic [N-2:0]     ONE_M  = (N-1)'(2**Q);
  localparam logic [Q+1:0]     ONE_O  = (Q+2)'(2**Q);

  // Clamp magnitude to 1.0, offset into 0..2.0, then scale onto 0..PERIOD_HALF.
  function automatic logic [CNT_W-1:0] to_cmp(input logic [N-1:0] r);
    logic [Q+1:0]  mc;
    logic [Q+1:0]  off;
    logic [PW-1:0] prod;
    if (r[N-2:0] > ONE_M) mc = ONE_O;
    else                  mc = (Q+2)'(r[N-2:0]);
    off  = r[N-1] ? (ONE_O - mc) : (ONE_O + mc);
    prod = PW'(off) * PW'(PERIOD_HALF);
    return prod[Q+1 +: CNT_W];
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             up;
  logic             sync;
  logic             tripped_q;
  logic             blocked;
  logic [CNT_W-1:0] conv   [3];
  logic [CNT_W-1:0] shadow [3];
  logic [CNT_W-1:0] active [3];
  logic [DW-1:0]    dcnt   [3];
  logic [DW-1:0]    dnext  [3];
  logic [2:0]       raw;
  logic [2:0]       raw_q;
  logic [2:0]       drive;
  logic [2:0]       gh;
  logic [2:0]       gl;

  always_comb begin
    conv[0] = to_cmp(ref_a);
    conv[1] = to_cmp(ref_b);
    conv[2] = to_cmp(ref_c);
    blocked = trip | tripped_q | ~en;
    raw     = '0;
    drive   = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      raw[i]   = (cnt < active[i]) || (active[i] == PH_C);
      if (raw[i] != raw_q[i])  dnext[i] = DEAD_C;
      else if (dcnt[i] != '0)  dnext[i] = dcnt[i] - DW'(1);
      else                     dnext[i] = '0;
      drive[i] = (dnext[i] == '0);
    end
  end

  // pwm_sync is registered alongside the count so it coincides with carrier = 0.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt  <= '0;
      up   <= 1'b1;
      sync <= 1'b0;
    end else if (up) begin
      sync <= 1'b0;
      if (cnt == PH_C) begin
        cnt <= PH_C - CNT_W'(1);
        up  <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt  <= cnt - CNT_W'(1);
      up   <= (cnt == CNT_W'(1));
      sync <= (cnt == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         tripped_q <= 1'b0;
    else if (trip)     tripped_q <= 1'b1;
    else if (trip_clr) tripped_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 3; i++) begin
        shadow[i] <= MID_C;
        active[i] <= MID_C;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (ref_valid)   shadow[i] <= conv[i];
        if (cnt == '0)   active[i] <= shadow[i];
      end
    end
  end

  // raw_q tracks raw even while blocked so re-enabling starts a clean DEAD countdown;
  // its reset value equals raw for the mid-scale compare at carrier 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q <= '1;
      gh    <= '0;
      gl    <= '0;
      for (int unsigned i = 0; i < 3; i++) dcnt[i] <= DEAD_C;
    end else begin
      raw_q <= raw;
      gh    <= blocked ? 3'b000 : (drive & raw);
      gl    <= blocked ? 3'b000 : (drive & ~raw);
      for (int unsigned i = 0; i < 3; i++) dcnt[i] <= blocked ? DEAD_C : dnext[i];
    end
  end

  assign gate_ah  = gh[0];
  assign gate_al  = gl[0];
  assign gate_bh  = gh[1];
  assign gate_bl  = gl[1];
  assign gate_ch  = gh[2];
  assign gate_cl  = gl[2];
  assign pwm_sync = sync;
  assign tripped  = tripped_q;
  assign carrier  = cnt;

endmodule

// File: tb/tb_mms_pwm_gen.sv
// Directed bench for mms_pwm_gen with default parameters (period 4096, dead time 8).
module tb_mms_pwm_gen;

  logic        clk = 1'b0;
  logic        reset, en, ref_valid, trip, trip_clr;
  logic [23:0] ref_a, ref_b, ref_c;
  logic        gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;
  logic        pwm_sync, tripped;
  logic [11:0] carrier;
  logic [5:0]  g;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int m_ah, m_al, m_bh, m_bl, m_ch, m_cl, m_ov;

  mms_pwm_gen dut (
    .clk(clk), .reset(reset), .en(en),
    .ref_a(ref_a), .ref_b(ref_b), .ref_c(ref_c), .ref_valid(ref_valid),
    .trip(trip), .trip_clr(trip_clr),
    .gate_ah(gate_ah), .gate_al(gate_al), .gate_bh(gate_bh),
    .gate_bl(gate_bl), .gate_ch(gate_ch), .gate_cl(gate_cl),
    .pwm_sync(pwm_sync), .tripped(tripped), .carrier(carrier)
  );

  always #5 clk = ~clk;
  assign g = {gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_sync();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!pwm_sync && n < 5000);
    total_cnt++;
    if (pwm_sync !== 1'b1 || carrier !== 12'd0)
      $display("FAIL wait_sync: pwm_sync=%b carrier=%0d after %0d cycles, expected 1/0", pwm_sync, carrier, n);
    else pass_cnt++;
  endtask

  // Count high cycles of every gate over one full carrier period.
  task automatic measure(output int ah, output int al, output int bh, output int bl,
                         output int ch, output int cl, output int ov);
    ah = 0; al = 0; bh = 0; bl = 0; ch = 0; cl = 0; ov = 0;
    for (int i = 0; i < 4096; i++) begin
      if (gate_ah) ah++;
      if (gate_al) al++;
      if (gate_bh) bh++;
      if (gate_bl) bl++;
      if (gate_ch) ch++;
      if (gate_cl) cl++;
      if ((gate_ah && gate_al) || (gate_bh && gate_bl) || (gate_ch && gate_cl)) ov++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic [5:0] exp_g;
    int cyc;
    reset = 1'b1; en = 1'b0; ref_valid = 1'b0; trip = 1'b0; trip_clr = 1'b0;
    ref_a = '0; ref_b = '0; ref_c = '0;
    repeat (3) tick();
    total_cnt++; if (g !== 6'b0)      $display("FAIL reset_gates: got %b expected 000000", g); else pass_cnt++;
    total_cnt++; if (carrier !== 12'd0) $display("FAIL reset_carrier: got %0d expected 0", carrier); else pass_cnt++;
    total_cnt++; if (tripped !== 1'b0) $display("FAIL reset_tripped: got %b expected 0", tripped); else pass_cnt++;
    total_cnt++; if (pwm_sync !== 1'b0) $display("FAIL reset_sync: got %b expected 0", pwm_sync); else pass_cnt++;
    reset = 1'b0; en = 1'b1;
    repeat (1000) tick();
    trip = 1'b1; tick(); trip = 1'b0;
    total_cnt++; if (tripped !== 1'b1) $display("FAIL pre_reset_trip: got %b expected 1", tripped); else pass_cnt++;
    reset = 1'b1; tick();
    total_cnt++; if (g !== 6'b0)       $display("FAIL midreset_gates: got %b expected 000000", g); else pass_cnt++;
    total_cnt++; if (carrier !== 12'd0) $display("FAIL midreset_carrier: got %0d expected 0", carrier); else pass_cnt++;
    total_cnt++; if (tripped !== 1'b0) $display("FAIL midreset_tripped: got %b expected 0", tripped); else pass_cnt++;
    total_cnt++; if (pwm_sync !== 1'b0) $display("FAIL midreset_sync: got %b expected 0", pwm_sync); else pass_cnt++;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = (k == 8) ? 6'b101010 : 6'b000000;
      total_cnt++; if (carrier !== k[11:0]) $display("FAIL release_carrier[%0d]: got %0d expected %0d", k, carrier, k); else pass_cnt++;
      total_cnt++; if (g !== exp_g) $display("FAIL release_gates[%0d]: got %b expected %b", k, g, exp_g); else pass_cnt++;
    end
    cyc = 8;
    while (!pwm_sync && cyc < 5000) begin
      tick();
      cyc++;
    end
    total_cnt++; if (cyc !== 4096) $display("FAIL first_sync_cycle: got %0d expected 4096", cyc); else pass_cnt++;
    total_cnt++; if (carrier !== 12'd0) $display("FAIL first_sync_carrier: got %0d expected 0", carrier); else pass_cnt++;
  endtask

  task automatic test_duty50();
    measure(m_ah, m_al, m_bh, m_bl, m_ch, m_cl, m_ov);
    total_cnt++; if (m_ah !== 2039) $display("FAIL duty50_ah: got %0d expected 2039", m_ah); else pass_cnt++;
    total_cnt++; if (m_al !== 2041) $display("FAIL duty50_al: got %0d expected 2041", m_al); else pass_cnt++;
    total_cnt++; if (m_bh !== 2039) $display("FAIL duty50_bh: got %0d expected 2039", m_bh); else pass_cnt++;
    total_cnt++; if (m_bl !== 2041) $display("FAIL duty50_bl: got %0d expected 2041", m_bl); else pass_cnt++;
    total_cnt++; if (m_ch !== 2039) $display("FAIL duty50_ch: got %0d expected 2039", m_ch); else pass_cnt++;
    total_cnt++; if (m_cl !== 2041) $display("FAIL duty50_cl: got %0d expected 2041", m_cl); else pass_cnt++;
    total_cnt++; if (m_ov !== 0)    $display("FAIL duty50_overlap: got %0d expected 0", m_ov); else pass_cnt++;
  endtask

  task automatic test_double_buffer();
    repeat (700) tick();
    total_cnt++; if (carrier !== 12'd700) $display("FAIL dbuf_carrier700: got %0d expected 700", carrier); else pass_cnt++;
    ref_a = 24'h000800; ref_valid = 1'b1; tick(); ref_valid = 1'b0;
    repeat (399) tick();
    total_cnt++; if (carrier !== 12'd1100) $display("FAIL dbuf_carrier1100: got %0d expected 1100", carrier); else pass_cnt++;
    total_cnt++; if ({gate_ah, gate_al} !== 2'b01) $display("FAIL dbuf_old_duty: got ah/al=%b expected 01", {gate_ah, gate_al}); else pass_cnt++;
    wait_sync();
    measure(m_ah, m_al, m_bh, m_bl, m_ch, m_cl, m_ov);
    total_cnt++; if (m_ah !== 3063) $display("FAIL dbuf_new_ah: got %0d expected 3063", m_ah); else pass_cnt++;
    total_cnt++; if (m_al !== 1017) $display("FAIL dbuf_new_al: got %0d expected 1017", m_al); else pass_cnt++;
    total_cnt++; if (m_bh !== 2039) $display("FAIL dbuf_b_steady: got %0d expected 2039", m_bh); else pass_cnt++;
    ref_a = 24'h800800; ref_valid = 1'b1; tick(); ref_valid = 1'b0;
    measure(m_ah, m_al, m_bh, m_bl, m_ch, m_cl, m_ov);
    total_cnt++; if (m_ah !== 3063) $display("FAIL valley_write_held_ah: got %0d expected 3063", m_ah); else pass_cnt++;
    total_cnt++; if (m_al !== 1017) $display("FAIL valley_write_held_al: got %0d expected 1017", m_al); else pass_cnt++;
    measure(m_ah, m_al, m_bh, m_bl, m_ch, m_cl, m_ov);
    total_cnt++; if (m_ah !== 1015) $display("FAIL valley_write_applied_ah: got %0d expected 1015", m_ah); else pass_cnt++;
    total_cnt++; if (m_al !== 3065) $display("FAIL valley_write_applied_al: got %0d expected 3065", m_al); else pass_cnt++;
  endtask

  task automatic test_scaling();
    repeat (10) tick();
    ref_a = 24'h000800; ref_b = 24'h800800; ref_c = 24'h800000;
    ref_valid = 1'b1; tick(); ref_valid = 1'b0;
    wait_sync();
    measure(m_ah, m_al, m_bh, m_bl, m_ch, m_cl, m_ov);
    total_cnt++; if (m_ah !== 3063) $display("FAIL scale_ah: got %0d expected 3063", m_ah); else pass_cnt++;
    total_cnt++; if (m_al !== 1017) $display("FAIL scale_al: got %0d expected 1017", m_al); else pass_cnt++;
    total_cnt++; if (m_bh !== 1015) $display("FAIL scale_bh: got %0d expected 1015", m_bh); else pass_cnt++;
    total_cnt++; if (m_bl !== 3065) $display("FAIL scale_bl: got %0d expected 3065", m_bl); else pass_cnt++;
    total_cnt++; if (m_ch !== 2039) $display("FAIL scale_ch_negzero: got %0d expected 2039", m_ch); else pass_cnt++;
    total_cnt++; if (m_cl !== 2041) $display("FAIL scale_cl_negzero: got %0d expected 2041", m_cl); else pass_cnt++;
    total_cnt++; if (m_ov !== 0)    $display("FAIL scale_overlap: got %0d expected 0", m_ov); else pass_cnt++;
  endtask

  task automatic test_saturation();
    repeat (10) tick();
    ref_a = 24'h002000; ref_b = 24'h802000;
    ref_valid = 1'b1; tick(); ref_valid = 1'b0;
    wait_sync();
    wait_sync();
    measure(m_ah, m_al, m_bh, m_bl, m_ch, m_cl, m_ov);
    total_cnt++; if (m_ah !== 4096) $display("FAIL sat_pos_ah: got %0d expected 4096", m_ah); else pass_cnt++;
    total_cnt++; if (m_al !== 0)    $display("FAIL sat_pos_al: got %0d expected 0", m_al); else pass_cnt++;
    total_cnt++; if (m_bh !== 0)    $display("FAIL sat_neg_bh: got %0d expected 0", m_bh); else pass_cnt++;
    total_cnt++; if (m_bl !== 4096) $display("FAIL sat_neg_bl: got %0d expected 4096", m_bl); else pass_cnt++;
    total_cnt++; if (m_ch !== 2039) $display("FAIL sat_c_steady: got %0d expected 2039", m_ch); else pass_cnt++;
  endtask

  task automatic test_trip();
    logic [5:0] exp_g;
    repeat (300) tick();
    total_cnt++; if (carrier !== 12'd300) $display("FAIL trip_carrier300: got %0d expected 300", carrier); else pass_cnt++;
    total_cnt++; if (g !== 6'b100110) $display("FAIL trip_pre_gates: got %b expected 100110", g); else pass_cnt++;
    trip = 1'b1; tick();
    total_cnt++; if (g !== 6'b0)      $display("FAIL trip_gates_off: got %b expected 000000", g); else pass_cnt++;
    total_cnt++; if (tripped !== 1'b1) $display("FAIL trip_latched: got %b expected 1", tripped); else pass_cnt++;
    trip_clr = 1'b1; tick();
    total_cnt++; if (tripped !== 1'b1) $display("FAIL trip_clr_ignored: got %b expected 1", tripped); else pass_cnt++;
    total_cnt++; if (g !== 6'b0)      $display("FAIL trip_clr_ignored_gates: got %b expected 000000", g); else pass_cnt++;
    trip = 1'b0; tick();
    trip_clr = 1'b0;
    total_cnt++; if (tripped !== 1'b0) $display("FAIL trip_cleared: got %b expected 0", tripped); else pass_cnt++;
    total_cnt++; if (g !== 6'b0)      $display("FAIL trip_clear_gates: got %b expected 000000", g); else pass_cnt++;
    total_cnt++; if (carrier !== 12'd303) $display("FAIL trip_carrier_runs: got %0d expected 303", carrier); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = (k == 8) ? 6'b100110 : 6'b000000;
      total_cnt++; if (g !== exp_g) $display("FAIL trip_resume[%0d]: got %b expected %b", k, g, exp_g); else pass_cnt++;
    end
  endtask

  task automatic test_enable();
    logic [5:0] exp_g;
    en = 1'b0; tick();
    total_cnt++; if (g !== 6'b0)        $display("FAIL en_off_gates: got %b expected 000000", g); else pass_cnt++;
    total_cnt++; if (carrier !== 12'd0)  $display("FAIL en_off_carrier: got %0d expected 0", carrier); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (carrier !== 12'd0 || pwm_sync !== 1'b0)
      $display("FAIL en_off_hold: got carrier=%0d sync=%b expected 0/0", carrier, pwm_sync); else pass_cnt++;
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = (k == 8) ? 6'b100110 : 6'b000000;
      total_cnt++; if (carrier !== k[11:0]) $display("FAIL en_on_carrier[%0d]: got %0d expected %0d", k, carrier, k); else pass_cnt++;
      total_cnt++; if (g !== exp_g) $display("FAIL en_on_gates[%0d]: got %b expected %b", k, g, exp_g); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_duty50();
    test_double_buffer();
    test_scaling();
    test_saturation();
    test_trip();
    test_enable();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
